// File: rtl/if_id_stage.sv
// IF/ID pipeline register: 2-entry skid buffer between fetch and decode, head entry split into MIPS fields.
// Optional IF_ID_STALL_CNT_EN adds a saturating count of cycles where decode stalls a valid head.
module if_id_stage #(
    parameter int unsigned INSN_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSN_W-1:0] in_insn,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INSN_W-1:0] out_insn,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [IMM_W-1:0]  out_imm,
    output logic [25:0]       out_target
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic              main_v_q, main_v_d;
    logic [INSN_W-1:0] main_insn_q, main_insn_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic              skid_v_q, skid_v_d;
    logic [INSN_W-1:0] skid_insn_q, skid_insn_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;

    logic acc;
    logic pop;

    // in_ready depends only on state, so decode backpressure never reaches fetch combinationally
    assign in_ready  = !skid_v_q;
    assign out_valid = main_v_q;
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        main_insn_d = main_insn_q;
        main_pc_d   = main_pc_q;
        skid_v_d    = skid_v_q;
        skid_insn_d = skid_insn_q;
        skid_pc_d   = skid_pc_q;

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q) begin
            if (acc) begin
                main_v_d    = 1'b1;
                main_insn_d = in_insn;
                main_pc_d   = in_pc;
            end
        end else if (pop) begin
            if (skid_v_q) begin
                main_insn_d = skid_insn_q;
                main_pc_d   = skid_pc_q;
                skid_v_d    = 1'b0;
            end else if (acc) begin
                main_insn_d = in_insn;
                main_pc_d   = in_pc;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (acc) begin
            // head is stalled: park the new beat in the skid slot
            skid_v_d    = 1'b1;
            skid_insn_d = in_insn;
            skid_pc_d   = in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            main_insn_q <= '0;
            main_pc_q   <= '0;
            skid_v_q    <= 1'b0;
            skid_insn_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_insn_q <= main_insn_d;
            main_pc_q   <= main_pc_d;
            skid_v_q    <= skid_v_d;
            skid_insn_q <= skid_insn_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign out_pc     = main_pc_q;
    assign out_insn   = main_insn_q;
    assign out_opcode = main_insn_q[31:26];
    assign out_rs     = main_insn_q[25:21];
    assign out_rt     = main_insn_q[20:16];
    assign out_rd     = main_insn_q[15:11];
    assign out_shamt  = main_insn_q[10:6];
    assign out_funct  = main_insn_q[5:0];
    assign out_imm    = main_insn_q[IMM_W-1:0];
    assign out_target = main_insn_q[25:0];

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: accepted beats queue expected {pc, insn}; a negedge monitor checks pops.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_insn;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [15:0] out_imm;
    logic [25:0] out_target;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    if_id_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_insn   (in_insn),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_insn  (out_insn),
        .out_opcode(out_opcode),
        .out_rs    (out_rs),
        .out_rt    (out_rt),
        .out_rd    (out_rd),
        .out_shamt (out_shamt),
        .out_funct (out_funct),
        .out_imm   (out_imm),
        .out_target(out_target)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] insn, input logic [31:0] pc);
        in_valid = 1'b1;
        in_insn  = insn;
        in_pc    = pc;
    endtask

    // Monitor: compare popped head against scoreboard, then record this cycle's acceptance
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_insn, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_pc", out_pc, e[63:32]);
                    chk("mon_insn", out_insn, e[31:0]);
                    chk("mon_opcode", {26'd0, out_opcode}, {26'd0, e[31:26]});
                    chk("mon_rs", {27'd0, out_rs}, {27'd0, e[25:21]});
                    chk("mon_rt", {27'd0, out_rt}, {27'd0, e[20:16]});
                    chk("mon_rd", {27'd0, out_rd}, {27'd0, e[15:11]});
                    chk("mon_shamt", {27'd0, out_shamt}, {27'd0, e[10:6]});
                    chk("mon_funct", {26'd0, out_funct}, {26'd0, e[5:0]});
                    chk("mon_imm", {16'd0, out_imm}, {16'd0, e[15:0]});
                    chk("mon_target", {6'd0, out_target}, {6'd0, e[25:0]});
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back({in_pc, in_insn});
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_insn   = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_insn", out_insn, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
`ifdef IF_ID_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Field decode, hand-computed
        out_ready = 1'b1;
        offer(32'h2008_FFFF, 32'h0040_0000);
        cyc();
        in_valid = 1'b0;
        chk("dec_valid", {31'd0, out_valid}, 32'd1);
        chk("dec_opcode", {26'd0, out_opcode}, 32'h08);
        chk("dec_rs", {27'd0, out_rs}, 32'd0);
        chk("dec_rt", {27'd0, out_rt}, 32'd8);
        chk("dec_rd", {27'd0, out_rd}, 32'd31);
        chk("dec_shamt", {27'd0, out_shamt}, 32'd31);
        chk("dec_funct", {26'd0, out_funct}, 32'h3F);
        chk("dec_imm", {16'd0, out_imm}, 32'hFFFF);
        chk("dec_target", {6'd0, out_target}, 32'h008_FFFF);
        chk("dec_pc", out_pc, 32'h0040_0000);
        cyc();
        chk("dec_drained", {31'd0, out_valid}, 32'd0);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            offer(32'h1000 + i, 32'h100 + 4 * i);
            cyc();
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_insn", out_insn, 32'h1000 + i);
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_end", {31'd0, out_valid}, 32'd0);

        // Backpressure: A to main, B to skid, C held at input
        out_ready = 1'b0;
        offer(32'hAAAA_0001, 32'h200);
        cyc();
        chk("bp_a_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
        offer(32'hBBBB_0002, 32'h204);
        cyc();
        chk("bp_b_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_b_head", out_insn, 32'hAAAA_0001);
        offer(32'hCCCC_0003, 32'h208);
        cyc();
        chk("bp_c_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_c_head", out_insn, 32'hAAAA_0001);
        out_ready = 1'b1;
        cyc();
        chk("bp_head_b", out_insn, 32'hBBBB_0002);
        chk("bp_ready_again", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("bp_head_c", out_insn, 32'hCCCC_0003);
        chk("bp_c_valid", {31'd0, out_valid}, 32'd1);
        cyc();
        chk("bp_done", {31'd0, out_valid}, 32'd0);

        // Flush with both entries full and D offered
        out_ready = 1'b0;
        offer(32'h1111_0001, 32'h300);
        cyc();
        offer(32'h2222_0002, 32'h304);
        cyc();
        chk("fl_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        offer(32'hDDDD_DDDD, 32'h308);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) cyc();
        chk("fl_no_d", {31'd0, out_valid}, 32'd0);

        // Flush drops a beat even when in_ready=1
        flush = 1'b1;
        offer(32'hEEEE_EEEE, 32'h30C);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_empty_drop", {31'd0, out_valid}, 32'd0);
        cyc();
        chk("fl_empty_drop2", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-cycle with both entries full
        out_ready = 1'b0;
        offer(32'h3333_0001, 32'h400);
        cyc();
        offer(32'h4444_0002, 32'h404);
        cyc();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_insn", out_insn, 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_opcode", {26'd0, out_opcode}, 32'd0);
        chk("arst_imm", {16'd0, out_imm}, 32'd0);
        chk("arst_target", {6'd0, out_target}, 32'd0);
        #3;
        rst = 1'b0;
        cyc();
        chk("arst_after", {31'd0, out_valid}, 32'd0);

`ifdef IF_ID_STALL_CNT_EN
        chk("stall_zero", stall_cnt, 32'd0);
        out_ready = 1'b0;
        offer(32'h5555_0001, 32'h500);
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        chk("stall_five", stall_cnt, 32'd5);
        flush     = 1'b1;
        out_ready = 1'b1;
        cyc();
        flush = 1'b0;
        chk("stall_flush", stall_cnt, 32'd5);
        cyc();
        chk("stall_hold", stall_cnt, 32'd5);
`endif

        cyc();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
